edge_count_scheduler: RTL

//  Sequences the edge counter through repeated gated count windows: clears it, opens the gate
//  for a programmed number of clk cycles, closes it, requests a save, and captures the result.

---
 rtl/edge_sched_pkg.sv | 40 ++++
 rtl/edge_sched_fifo.sv | 43 ++++
 rtl/edge_count_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/edge_sched_pkg.sv
// Shared types and constants for the edge counter window scheduler.
// EDGE_SCHED_TIMESTAMP_EN adds the counter's 64-bit timestamp to each result word.
package edge_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ARM,
        GATE,
        CLOSE,
        SAVE,
        WAIT_WR,
        GAP
    } state_t;

    localparam logic [63:0] CMD_START = 64'h1;
    localparam logic [63:0] CMD_STOP  = 64'h2;
    localparam logic [63:0] CMD_SAVE  = 64'h4;
    localparam logic [63:0] CMD_RESET = 64'h8;

    localparam int WR_TIMEOUT = 64;

`ifdef EDGE_SCHED_TIMESTAMP_EN
    localparam int TS_W = 64;
`else
    localparam int TS_W = 0;
`endif

    // Command issued on the cycle the scheduler sits in a given state.
    function automatic logic [63:0] state_cmd(input state_t s);
        case (s)
            CLR:     return CMD_RESET;
            ARM:     return CMD_START;
            CLOSE:   return CMD_STOP;
            SAVE:    return CMD_SAVE;
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/edge_sched_fifo.sv
// Synchronous result FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module edge_sched_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/edge_count_scheduler.sv
// Runs the edge counter through repeated gated windows and queues captured counts for readout.
// EDGE_SCHED_TIMESTAMP_EN prepends cnt_data[127:64] to every result word.
module edge_count_scheduler
    import edge_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [WIN_W-1:0]              window_len,
    input  logic [WIN_W-1:0]              gap_len,
    input  logic [15:0]                   num_windows,
    output logic [63:0]                   cmd_out,
    input  logic                          cnt_write,
    input  logic [127:0]                  cnt_data,
    output logic [TS_W+16+DATA_WIDTH-1:0] res_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);
    localparam int               RES_W    = TS_W + 16 + DATA_WIDTH;
    localparam int               TMO_W    = $clog2(WR_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);

    state_t           state, state_d;
    logic [63:0]      cmd_d;
    logic [WIN_W-1:0] wlen_q, gap_q, tcnt;
    logic [15:0]      nwin_q, win_done, win_idx;
    logic [TMO_W-1:0] tmo;
    logic             run_go, last_win, wr_timeout, win_end;
    logic             push, pop, fifo_full, fifo_empty;
    logic [RES_W-1:0] push_word;
    logic             unused_cnt_bits;

    assign run_go     = (state == IDLE) && start && !abort;
    assign last_win   = (nwin_q != 16'd0) && (win_done + 16'd1 == nwin_q);
    assign wr_timeout = (state == WAIT_WR) && !cnt_write && (tmo == TMO_LAST);
    assign win_end    = (state == WAIT_WR) && (cnt_write || wr_timeout);
    assign push       = (state == WAIT_WR) && cnt_write;
    assign pop        = res_ready && !fifo_empty;
    assign busy       = (state != IDLE);
    assign res_valid  = !fifo_empty;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (run_go) state_d = CLR;
            CLR:     state_d = ARM;
            ARM:     state_d = (wlen_q == WIN_W'(1)) ? CLOSE : GATE;
            GATE:    if (tcnt == '0) state_d = CLOSE;
            CLOSE:   state_d = SAVE;
            SAVE:    state_d = WAIT_WR;
            WAIT_WR: if (win_end) state_d = last_win ? IDLE : ((gap_q == '0) ? CLR : GAP);
            GAP:     if (tcnt == '0) state_d = CLR;
            default: state_d = IDLE;
        endcase
        if (abort && (state != IDLE)) state_d = IDLE;
        // An abort with the gate open still has to close it on the way out.
        if (abort && ((state == ARM) || (state == GATE)))
            cmd_d = CMD_STOP;
        else
            cmd_d = state_cmd(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cmd_out <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cmd_out <= cmd_d;
            done    <= (state != IDLE) && (state_d == IDLE);
        end
    end

    // Run parameters are frozen at start so host writes mid-run have no effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wlen_q   <= WIN_W'(1);
            gap_q    <= '0;
            nwin_q   <= '0;
            win_done <= '0;
            win_idx  <= '0;
        end else if (run_go) begin
            wlen_q   <= (window_len == '0) ? WIN_W'(1) : window_len;
            gap_q    <= gap_len;
            nwin_q   <= num_windows;
            win_done <= '0;
            win_idx  <= '0;
        end else begin
            if (win_end) win_done <= win_done + 16'd1;
            if (push)    win_idx  <= win_idx + 16'd1;
        end
    end

    // GATE holds window_len-1 cycles so STOP lands window_len cycles after START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
            tmo  <= '0;
        end else begin
            if (state == ARM)
                tcnt <= wlen_q - WIN_W'(2);
            else if (state == WAIT_WR)
                tcnt <= gap_q - WIN_W'(1);
            else if (tcnt != '0)
                tcnt <= tcnt - WIN_W'(1);
            tmo <= (state == WAIT_WR) ? tmo + TMO_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (run_go)
            overflow <= 1'b0;
        else if (wr_timeout || (push && fifo_full && !pop))
            overflow <= 1'b1;
    end

`ifdef EDGE_SCHED_TIMESTAMP_EN
    assign push_word = {cnt_data[127:64], win_idx, cnt_data[DATA_WIDTH-1:0]};
`else
    assign push_word = {win_idx, cnt_data[DATA_WIDTH-1:0]};
`endif
    assign unused_cnt_bits = ^cnt_data[127:DATA_WIDTH];

    edge_sched_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (push_word),
        .dout    (res_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
